// File: rtl/mont_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mont_pkg : shared types and sizing helpers for Montgomery blocks  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package mont_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ITER  = 2'd1,
      FINAL = 2'd2
   } mont_state_t;

   localparam int MONT_DATA_WIDTH = 8;
   localparam int CNT_W           = $clog2(MONT_DATA_WIDTH) + 1;

   // Counter width able to hold the value DATA_WIDTH itself (k can equal the width).
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage : mont_pkg
`default_nettype wire

// File: rtl/mont_bitlen.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mont_bitlen : priority encoder, modulus -> bit length k           |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module mont_bitlen
   import mont_pkg::*;
#(
   parameter int DATA_WIDTH = MONT_DATA_WIDTH,
   parameter int CW         = CNT_W
) (
   input  logic [DATA_WIDTH-1:0] i_modulant,
   output logic [CW-1:0]         o_k
);

   // Ascending scan: the highest set bit is the last one to write o_k.
   always_comb begin
      o_k = '0;
      for (int j = 0; j < DATA_WIDTH; j++) begin
         if (i_modulant[j]) begin
            o_k = CW'(j + 1);
         end
      end
   end

endmodule : mont_bitlen
`default_nettype wire

// File: rtl/montgomery_mult.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | montgomery_mult : radix-2 bit-serial a*b*2^-k mod N, k = bitlen(N) |
// | Optional operand/modulus checking: MONT_RANGE_CHECK_EN. Rev 1.0    |
// +-------------------------------------------------------------------+
module montgomery_mult
   import mont_pkg::*;
#(
   parameter int DATA_WIDTH = MONT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [DATA_WIDTH-1:0] modulant,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int c_CW = cnt_width(DATA_WIDTH);
   localparam int c_SW = DATA_WIDTH + 2;

   mont_state_t           r_state;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic [DATA_WIDTH-1:0] r_n;
   logic [c_SW-1:0]       r_s;
   logic [c_CW-1:0]       r_i;
   logic [c_CW-1:0]       r_k;
   logic                  r_viol;

   logic [c_CW-1:0]       w_k;
   logic                  w_abit;
   logic                  w_last;
   logic                  w_bad;
   logic [c_SW-1:0]       w_t0;
   logic [c_SW-1:0]       w_t1;
   logic [c_SW-1:0]       w_snext;
   logic [c_SW-1:0]       w_res;
   logic                  w_unused;

   mont_bitlen #(
      .DATA_WIDTH (DATA_WIDTH),
      .CW         (c_CW)
   ) u_bitlen (
      .i_modulant (modulant),
      .o_k        (w_k)
   );

   always_comb begin
      w_abit = 1'b0;
      for (int j = 0; j < DATA_WIDTH; j++) begin
         if (r_i == c_CW'(j)) begin
            w_abit = r_a[j];
         end
      end
   end

   // S < 2N and b < N keep every intermediate below 4N, inside c_SW bits.
   assign w_t0     = r_s + (w_abit ? {2'b00, r_b} : {c_SW{1'b0}});
   assign w_t1     = w_t0[0] ? (w_t0 + {2'b00, r_n}) : w_t0;
   assign w_snext  = w_t1 >> 1;
   assign w_last   = (r_i == (r_k - c_CW'(1)));
   assign w_res    = (r_s >= {2'b00, r_n}) ? (r_s - {2'b00, r_n}) : r_s;
   assign w_unused = ^w_res[c_SW-1:DATA_WIDTH];

`ifdef MONT_RANGE_CHECK_EN
   logic r_err;

   assign w_bad = ~modulant[0] | (modulant < DATA_WIDTH'(3)) | (a >= modulant) | (b >= modulant);
   assign err   = r_err;
`else
   assign w_bad = 1'b0;
   assign err   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_n     <= '0;
         r_s     <= '0;
         r_i     <= '0;
         r_k     <= '0;
         r_viol  <= 1'b0;
         out     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef MONT_RANGE_CHECK_EN
         r_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_n     <= modulant;
                  r_s     <= '0;
                  r_i     <= '0;
                  r_k     <= w_k;
                  r_viol  <= w_bad;
                  busy    <= 1'b1;
`ifdef MONT_RANGE_CHECK_EN
                  r_err   <= 1'b0;
`endif
                  r_state <= w_bad ? FINAL : ITER;
               end
            end
            ITER: begin
               r_s <= w_snext;
               r_i <= r_i + c_CW'(1);
               if (w_last) begin
                  r_state <= FINAL;
               end
            end
            FINAL: begin
               busy    <= 1'b0;
               done    <= 1'b1;
               r_state <= IDLE;
               if (r_viol) begin
                  out   <= '0;
`ifdef MONT_RANGE_CHECK_EN
                  r_err <= 1'b1;
`endif
               end else begin
                  out   <= w_res[DATA_WIDTH-1:0];
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule : montgomery_mult
`default_nettype wire

// File: tb/tb_montgomery_mult.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_montgomery_mult : directed self-checking bench, DATA_WIDTH = 8 |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_montgomery_mult;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] modulant;
   logic [7:0] out;
   logic       busy;
   logic       done;
   logic       err;

   int n_checks = 0;
   int n_pass   = 0;

   montgomery_mult #(.DATA_WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .modulant (modulant),
      .out      (out),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge; returns at the negedge where done is seen (or on timeout).
   // cyc = edges after the accepting edge until done; bcyc = busy samples before done.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tn,
                        output int cyc, output int bcyc, output logic [7:0] res, output logic rerr);
      a = ta; b = tb; modulant = tn; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0; bcyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy === 1'b1) bcyc++;
         @(negedge clk);
         cyc++;
      end
      res = out; rerr = err;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; modulant = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({out, busy, done, err} !== 11'd0) $display("FAIL reset_outputs: got out=%0d busy=%b done=%b err=%b, need all 0", out, busy, done, err);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, done} !== 2'b00) $display("FAIL reset_idle: got busy=%b done=%b, need 0 0", busy, done);
      else n_pass++;
   endtask

   task automatic test_basic;
      int cyc, bcyc; logic [7:0] res; logic rerr;
      do_op(8'd5, 8'd7, 8'd13, cyc, bcyc, res, rerr);
      n_checks++;
      if (res !== 8'd3) $display("FAIL basic_out: got %0d, need 3", res); else n_pass++;
      n_checks++;
      if (cyc !== 5) $display("FAIL basic_latency: got %0d edges, need 5", cyc); else n_pass++;
      n_checks++;
      if (bcyc !== 5) $display("FAIL basic_busy_len: got %0d cycles, need 5", bcyc); else n_pass++;
      n_checks++;
      if (rerr !== 1'b0) $display("FAIL basic_err: got %b, need 0", rerr); else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({done, out} !== {1'b0, 8'd3}) $display("FAIL basic_done_pulse: got done=%b out=%0d, need done=0 out=3", done, out);
      else n_pass++;
   endtask

   task automatic test_domain;
      int cyc, bcyc; logic [7:0] res; logic rerr;
      do_op(8'd7, 8'd9, 8'd13, cyc, bcyc, res, rerr);
      n_checks++;
      if (res !== 8'd8) $display("FAIL domain_in: got %0d, need 8", res); else n_pass++;
      do_op(8'd8, 8'd1, 8'd13, cyc, bcyc, res, rerr);
      n_checks++;
      if (res !== 8'd7) $display("FAIL domain_out: got %0d, need 7", res); else n_pass++;
   endtask

   task automatic test_full_width;
      int cyc, bcyc; logic [7:0] res; logic rerr;
      do_op(8'd254, 8'd254, 8'd255, cyc, bcyc, res, rerr);
      n_checks++;
      if (res !== 8'd1) $display("FAIL full_out: got %0d, need 1", res); else n_pass++;
      n_checks++;
      if (cyc !== 9) $display("FAIL full_latency: got %0d edges, need 9", cyc); else n_pass++;
      do_op(8'd0, 8'd200, 8'd255, cyc, bcyc, res, rerr);
      n_checks++;
      if (res !== 8'd0) $display("FAIL full_zero: got %0d, need 0", res); else n_pass++;
   endtask

   task automatic test_start_while_busy;
      int cyc, bcyc, extra; logic [7:0] res; logic rerr;
      do_op(8'd12, 8'd12, 8'd13, cyc, bcyc, res, rerr);
      n_checks++;
      if (res !== 8'd9) $display("FAIL sq12_out: got %0d, need 9", res); else n_pass++;
      a = 8'd5; b = 8'd7; modulant = 8'd13; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'd100; b = 8'd33; modulant = 8'd255; start = 1'b1;
      n_checks++;
      if (out !== 8'd9) $display("FAIL hold_out: got %0d mid-op, need 9", out); else n_pass++;
      @(negedge clk);
      start = 1'b0;
      cyc = 3;
      while (done !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (out !== 8'd3) $display("FAIL busy_start_out: got %0d, need 3", out); else n_pass++;
      n_checks++;
      if (cyc !== 5) $display("FAIL busy_start_latency: got %0d edges, need 5", cyc); else n_pass++;
      extra = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      n_checks++;
      if (extra !== 0) $display("FAIL busy_start_extra: got %0d extra busy/done cycles, need 0", extra); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int cyc, bcyc; logic [7:0] res; logic rerr;
      do_op(8'd5, 8'd7, 8'd13, cyc, bcyc, res, rerr);
      do_op(8'd254, 8'd254, 8'd255, cyc, bcyc, res, rerr);
      n_checks++;
      if (res !== 8'd1) $display("FAIL b2b_out: got %0d, need 1", res); else n_pass++;
      n_checks++;
      if (cyc !== 9) $display("FAIL b2b_latency: got %0d edges, need 9", cyc); else n_pass++;
      do_op(8'd7, 8'd9, 8'd13, cyc, bcyc, res, rerr);
      n_checks++;
      if (res !== 8'd8) $display("FAIL b2b_third: got %0d, need 8", res); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int cyc, bcyc; logic [7:0] res; logic rerr;
      a = 8'd12; b = 8'd12; modulant = 8'd13; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out, busy, done, err} !== 11'd0) $display("FAIL mid_reset: got out=%0d busy=%b done=%b err=%b, need all 0", out, busy, done, err);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op(8'd7, 8'd9, 8'd13, cyc, bcyc, res, rerr);
      n_checks++;
      if (res !== 8'd8) $display("FAIL after_reset_out: got %0d, need 8", res); else n_pass++;
      n_checks++;
      if (cyc !== 5) $display("FAIL after_reset_latency: got %0d edges, need 5", cyc); else n_pass++;
   endtask

   task automatic test_range;
      int cyc, bcyc; logic [7:0] res; logic rerr;
`ifdef MONT_RANGE_CHECK_EN
      do_op(8'd5, 8'd7, 8'd12, cyc, bcyc, res, rerr);
      n_checks++;
      if ({cyc, rerr, res} !== {32'd1, 1'b1, 8'd0}) $display("FAIL range_even: got edges=%0d err=%b out=%0d, need 1 1 0", cyc, rerr, res);
      else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++;
      if (err !== 1'b1) $display("FAIL range_err_hold: got %b, need 1", err); else n_pass++;
      do_op(8'd13, 8'd1, 8'd13, cyc, bcyc, res, rerr);
      n_checks++;
      if ({cyc, rerr, res} !== {32'd1, 1'b1, 8'd0}) $display("FAIL range_a_big: got edges=%0d err=%b out=%0d, need 1 1 0", cyc, rerr, res);
      else n_pass++;
      do_op(8'd5, 8'd7, 8'd13, cyc, bcyc, res, rerr);
      n_checks++;
      if ({rerr, res} !== {1'b0, 8'd3}) $display("FAIL range_clear: got err=%b out=%0d, need 0 3", rerr, res);
      else n_pass++;
`else
      do_op(8'd5, 8'd7, 8'd12, cyc, bcyc, res, rerr);
      n_checks++;
      if (rerr !== 1'b0) $display("FAIL range_err_tied: got %b, need 0", rerr); else n_pass++;
      n_checks++;
      if (cyc !== 5) $display("FAIL range_latency: got %0d edges, need 5", cyc); else n_pass++;
`endif
   endtask

   initial begin
      test_reset;
      test_basic;
      test_domain;
      test_full_width;
      test_start_while_busy;
      test_back_to_back;
      test_reset_mid;
      test_range;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_montgomery_mult
`default_nettype wire
